// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt pulse arbiter.
//   ch_state_t  : per-channel request state (idle / pending / waiting for release)
//   arb_state_t : arbiter state (idle / interrupt asserted / mandatory low gap)
//   id_width()  : width of a channel index, never less than one bit
package intr_pkg;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_PEND,
      CH_WAIT
   } ch_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_GAP
   } arb_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/intr_chan.sv
// One request channel: input synchroniser followed by the press FSM.
//   CLK     : system clock, rising edge
//   RESET_N : asynchronous active-low reset
//   PRESS   : raw asynchronous request input, active high
//   GRANT   : arbiter grant for this channel (only meaningful while pending)
//   PEND    : channel holds an unserved request
module intr_chan
   import intr_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic PRESS,
   input  logic GRANT,
   output logic PEND
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sp;
   ch_state_t              state;
   ch_state_t              state_n;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], PRESS};
      end
   end

   assign sp = sync[SYNC_STAGES-1];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= CH_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // A press is only re-armed once the synchronised input has been seen low
   // after the grant; anything the input does while pending or waiting is ignored.
   always_comb begin
      state_n = state;
      case (state)
         CH_IDLE: if (sp)    state_n = CH_PEND;
         CH_PEND: if (GRANT) state_n = CH_WAIT;
         CH_WAIT: if (!sp)   state_n = CH_IDLE;
         default:            state_n = CH_IDLE;
      endcase
   end

   assign PEND = (state == CH_PEND);

endmodule

// File: rtl/intr_pulse_arb.sv
// Multi-channel interrupt pulse arbiter.
// Each channel turns one press into one request; requests are served one at a
// time by fixed priority (lowest index first) and drive INTR as a fixed-width
// pulse (MODE_ACK=0) or as a level held until INTR_ACK (MODE_ACK=1).
//   CLK      : system clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   PRESS    : raw asynchronous request inputs, active high
//   INTR_ACK : CPU acknowledge, only honoured in MODE_ACK=1 while asserted
//   INTR     : registered interrupt line to the CPU
//   INTR_ID  : index of the channel being served, holds after INTR falls
//   PEND     : per-channel pending flags
//   BUSY     : arbiter is not idle
module intr_pulse_arb
   import intr_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int PULSE_LEN   = 6,
   parameter int MODE_ACK    = 0,
   parameter int SYNC_STAGES = 2,
   localparam int ID_W       = id_width(N_CH)
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic [N_CH-1:0] PRESS,
   input  logic            INTR_ACK,
   output logic            INTR,
   output logic [ID_W-1:0] INTR_ID,
   output logic [N_CH-1:0] PEND,
   output logic            BUSY
);

   localparam int CNT_W = $clog2(PULSE_LEN + 1);

   logic [N_CH-1:0] ch_pend;
   logic [N_CH-1:0] grant;
   logic            any_pend;
   logic [ID_W-1:0] pick_id;

   arb_state_t      state;
   arb_state_t      state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] id_n;
   logic            intr_q;
   logic            intr_n;

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      intr_chan #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .CLK     (CLK),
         .RESET_N (RESET_N),
         .PRESS   (PRESS[g]),
         .GRANT   (grant[g]),
         .PEND    (ch_pend[g])
      );
   end

   // Lowest pending index wins. The grant is only issued from idle, so it
   // coincides with the edge on which the arbiter enters ST_ASSERT.
   always_comb begin
      pick_id  = '0;
      any_pend = 1'b0;
      grant    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!any_pend && ch_pend[i]) begin
            pick_id  = ID_W'(i);
            any_pend = 1'b1;
            grant[i] = (state == ST_IDLE);
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      id_n    = id_q;
      case (state)
         ST_IDLE: begin
            if (any_pend) begin
               state_n = ST_ASSERT;
               cnt_n   = CNT_W'(PULSE_LEN - 1);
               id_n    = pick_id;
            end
         end
         ST_ASSERT: begin
            if (MODE_ACK != 0) begin
               if (INTR_ACK) state_n = ST_GAP;
            end else if (cnt == '0) begin
               state_n = ST_GAP;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         ST_GAP:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      // INTR is a flop loaded from the next state so it rises on the grant edge.
      intr_n = (state_n == ST_ASSERT);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         id_q   <= '0;
         intr_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         id_q   <= id_n;
         intr_q <= intr_n;
      end
   end

   assign INTR    = intr_q;
   assign INTR_ID = id_q;
   assign PEND    = ch_pend;
   assign BUSY    = (state != ST_IDLE);

endmodule

// File: tb/tb_intr_pulse_arb.sv
module tb_intr_pulse_arb;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // default pulse-mode instance
   logic       rst_d = 1'b0;
   logic [3:0] press_d = '0;
   logic       ack_d = 1'b0;
   logic       intr_d;
   logic [1:0] id_d;
   logic [3:0] pend_d;
   logic       busy_d;

   // acknowledge-mode instance
   logic       rst_a = 1'b0;
   logic [3:0] press_a = '0;
   logic       ack_a = 1'b0;
   logic       intr_a;
   logic [1:0] id_a;
   logic [3:0] pend_a;
   logic       busy_a;

   // single channel, one-cycle pulse instance
   logic       rst_o = 1'b0;
   logic [0:0] press_o = '0;
   logic       ack_o = 1'b0;
   logic       intr_o;
   logic [0:0] id_o;
   logic [0:0] pend_o;
   logic       busy_o;

   intr_pulse_arb #(.N_CH(4), .PULSE_LEN(6), .MODE_ACK(0), .SYNC_STAGES(2)) dut_d (
      .CLK(CLK), .RESET_N(rst_d), .PRESS(press_d), .INTR_ACK(ack_d),
      .INTR(intr_d), .INTR_ID(id_d), .PEND(pend_d), .BUSY(busy_d));

   intr_pulse_arb #(.N_CH(4), .PULSE_LEN(6), .MODE_ACK(1), .SYNC_STAGES(2)) dut_a (
      .CLK(CLK), .RESET_N(rst_a), .PRESS(press_a), .INTR_ACK(ack_a),
      .INTR(intr_a), .INTR_ID(id_a), .PEND(pend_a), .BUSY(busy_a));

   intr_pulse_arb #(.N_CH(1), .PULSE_LEN(1), .MODE_ACK(0), .SYNC_STAGES(2)) dut_o (
      .CLK(CLK), .RESET_N(rst_o), .PRESS(press_o), .INTR_ACK(ack_o),
      .INTR(intr_o), .INTR_ID(id_o), .PEND(pend_o), .BUSY(busy_o));

   typedef struct {
      int id;
      int start;
      int len;
   } exp_t;

   exp_t q_d[$];
   exp_t q_a[$];
   exp_t q_o[$];

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input int act, input int req);
      nvec++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic expect_pulse(input int which, input int id, input int start, input int len);
      exp_t e;
      e.id = id;
      e.start = start;
      e.len = len;
      case (which)
         0:       q_d.push_back(e);
         1:       q_a.push_back(e);
         default: q_o.push_back(e);
      endcase
   endtask

   task automatic wait_cyc(input int k);
      repeat (k) @(negedge CLK);
   endtask

   // Monitor: every rising INTR pops one expected pulse and checks its ID,
   // start cycle and the low gap before it; every falling INTR checks length.
   logic prev[3];
   int   hi[3];
   int   lo[3];
   int   elen[3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         prev[i] = 1'b0;
         hi[i]   = 0;
         lo[i]   = 99;
         elen[i] = -1;
      end
   end

   always @(negedge CLK) begin
      for (int i = 0; i < 3; i++) begin
         logic iv;
         logic rv;
         int   idv;
         exp_t e;
         bit   ok;
         case (i)
            0:       begin iv = intr_d; rv = rst_d; idv = int'(id_d); end
            1:       begin iv = intr_a; rv = rst_a; idv = int'(id_a); end
            default: begin iv = intr_o; rv = rst_o; idv = int'(id_o); end
         endcase
         if (!rv) begin
            hi[i]   = 0;
            lo[i]   = 99;
            elen[i] = -1;
         end else if (iv && !prev[i]) begin
            ok = 1'b0;
            case (i)
               0:       if (q_d.size() > 0) begin e = q_d.pop_front(); ok = 1'b1; end
               1:       if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
               default: if (q_o.size() > 0) begin e = q_o.pop_front(); ok = 1'b1; end
            endcase
            if (!ok) begin
               chk($sformatf("unexpected_pulse_dut%0d", i), 1, 0);
               elen[i] = -1;
            end else begin
               chk($sformatf("intr_id_dut%0d", i), idv, e.id);
               chk($sformatf("pulse_start_dut%0d", i), cyc, e.start);
               elen[i] = e.len;
            end
            chk($sformatf("low_gap_ge2_dut%0d", i), int'(lo[i] >= 2), 1);
            hi[i] = 1;
         end else if (iv) begin
            hi[i]++;
         end else if (prev[i]) begin
            if (elen[i] > 0) chk($sformatf("pulse_len_dut%0d", i), hi[i], elen[i]);
            lo[i] = 1;
         end else begin
            lo[i]++;
         end
         prev[i] = iv;
      end
   end

   int n;
   int m;

   initial begin
      // reset state
      wait_cyc(3);
      chk("rst_intr_d", int'(intr_d), 0);
      chk("rst_id_d", int'(id_d), 0);
      chk("rst_pend_d", int'(pend_d), 0);
      chk("rst_busy_d", int'(busy_d), 0);
      chk("rst_intr_a", int'(intr_a), 0);
      chk("rst_pend_a", int'(pend_a), 0);
      chk("rst_intr_o", int'(intr_o), 0);
      chk("rst_busy_o", int'(busy_o), 0);
      rst_d = 1'b1;
      rst_a = 1'b1;
      rst_o = 1'b1;
      wait_cyc(2);

      // single press held 20 cycles, ACK ignored in pulse mode
      n = cyc;
      press_d[2] = 1'b1;
      expect_pulse(0, 2, n + 4, 6);
      wait_cyc(3);
      chk("pend_before_grant", int'(pend_d), 4);
      chk("busy_before_grant", int'(busy_d), 0);
      wait_cyc(1);
      chk("pend_after_grant", int'(pend_d), 0);
      chk("busy_after_grant", int'(busy_d), 1);
      ack_d = 1'b1;
      wait_cyc(2);
      ack_d = 1'b0;
      wait_cyc(14);
      press_d[2] = 1'b0;
      wait_cyc(5);
      chk("id_holds_after_pulse", int'(id_d), 2);
      chk("intr_low_after_pulse", int'(intr_d), 0);
      n = cyc;
      press_d[2] = 1'b1;
      expect_pulse(0, 2, n + 4, 6);
      wait_cyc(12);
      press_d[2] = 1'b0;
      wait_cyc(6);

      // simultaneous requests on channels 1 and 3
      n = cyc;
      press_d[1] = 1'b1;
      press_d[3] = 1'b1;
      expect_pulse(0, 1, n + 4, 6);
      expect_pulse(0, 3, n + 12, 6);
      wait_cyc(11);
      chk("pend_ch3_waiting", int'(pend_d), 8);
      chk("busy_idle_between", int'(busy_d), 0);
      wait_cyc(14);
      press_d[1] = 1'b0;
      press_d[3] = 1'b0;
      wait_cyc(6);

      // reset mid-pulse, then exactly one new pulse with PRESS[0] still high
      n = cyc;
      press_d[0] = 1'b1;
      expect_pulse(0, 0, n + 4, 6);
      wait_cyc(6);
      chk("intr_high_before_reset", int'(intr_d), 1);
      @(posedge CLK);
      #2 rst_d = 1'b0;
      #1;
      chk("async_reset_intr", int'(intr_d), 0);
      chk("async_reset_pend", int'(pend_d), 0);
      chk("async_reset_busy", int'(busy_d), 0);
      wait_cyc(3);
      rst_d = 1'b1;
      m = cyc;
      expect_pulse(0, 0, m + 4, 6);
      wait_cyc(15);
      press_d[0] = 1'b0;
      wait_cyc(6);

      // ack mode: level held without ACK; bounce on ch0 while it sits pending
      n = cyc;
      press_a[1] = 1'b1;
      expect_pulse(1, 1, n + 4, 51);
      wait_cyc(6);
      for (int k = 0; k < 10; k++) begin
         press_a[0] = (k % 2 == 0);
         wait_cyc(1);
      end
      press_a[0] = 1'b0;
      press_a[1] = 1'b0;
      wait_cyc(14);
      chk("ack_intr_held_30", int'(intr_a), 1);
      chk("ack_id_held", int'(id_a), 1);
      chk("ack_pend_ch0_only", int'(pend_a), 1);
      wait_cyc(24);
      chk("ack_intr_held_54", int'(intr_a), 1);
      chk("ack_busy_held", int'(busy_a), 1);
      ack_a = 1'b1;
      expect_pulse(1, 0, n + 57, 6);
      wait_cyc(1);
      ack_a = 1'b0;
      chk("ack_intr_drops", int'(intr_a), 0);
      wait_cyc(7);
      ack_a = 1'b1;
      wait_cyc(1);
      ack_a = 1'b0;
      wait_cyc(5);
      ack_a = 1'b1;
      wait_cyc(1);
      ack_a = 1'b0;
      chk("idle_ack_busy", int'(busy_a), 0);
      wait_cyc(3);
      chk("idle_ack_intr", int'(intr_a), 0);
      chk("idle_ack_pend", int'(pend_a), 0);

      // one channel, one-cycle pulses
      n = cyc;
      press_o[0] = 1'b1;
      expect_pulse(2, 0, n + 4, 1);
      wait_cyc(4);
      chk("one_intr_high", int'(intr_o), 1);
      chk("one_id_zero", int'(id_o), 0);
      wait_cyc(1);
      chk("one_intr_low", int'(intr_o), 0);
      wait_cyc(3);
      press_o[0] = 1'b0;
      wait_cyc(4);
      n = cyc;
      press_o[0] = 1'b1;
      expect_pulse(2, 0, n + 4, 1);
      wait_cyc(6);
      press_o[0] = 1'b0;
      wait_cyc(10);

      chk("leftover_dut0", q_d.size(), 0);
      chk("leftover_dut1", q_a.size(), 0);
      chk("leftover_dut2", q_o.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
